wb_port_scheduler: RTL

- Schedules register-file writebacks for the 2-way core.
- Way 0 and way 1 pipeline results always get a write port. The long-latency mul/div unit result takes whichever port is idle, and is buffered in a small FIFO when both ports are busy.
- Drives both register-file write ports plus the Way_0_oldest_WB ordering flag, all registered.
- Cancels buffered mul/div results that a younger pipeline write to the same register has made stale (WAW safety).

---
 rtl/wb_port_scheduler_if.sv | 38 +++
 rtl/wb_port_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wb_port_scheduler_if.sv
// Writeback bus between the 2-way pipeline / mul/div unit and the scheduler.
// slave = scheduler side, master = pipeline/mul-div/register-file side.
interface wb_port_scheduler_if;
  logic        w0_valid;
  logic [4:0]  w0_reg;
  logic [31:0] w0_data;
  logic        w1_valid;
  logic [4:0]  w1_reg;
  logic [31:0] w1_data;
  logic        w0_oldest;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        RegWrite1;
  logic [4:0]  WriteReg_WB1;
  logic [31:0] WriteData1;
  logic        RegWrite2;
  logic [4:0]  WriteReg_WB2;
  logic [31:0] WriteData2;
  logic        Way_0_oldest_WB;

  modport slave (
    input  w0_valid, w0_reg, w0_data, w1_valid, w1_reg, w1_data, w0_oldest,
    input  md_valid, md_reg, md_data,
    output md_ready,
    output RegWrite1, WriteReg_WB1, WriteData1,
    output RegWrite2, WriteReg_WB2, WriteData2, Way_0_oldest_WB
  );

  modport master (
    output w0_valid, w0_reg, w0_data, w1_valid, w1_reg, w1_data, w0_oldest,
    output md_valid, md_reg, md_data,
    input  md_ready,
    input  RegWrite1, WriteReg_WB1, WriteData1,
    input  RegWrite2, WriteReg_WB2, WriteData2, Way_0_oldest_WB
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler: pipeline ways own ports, mul/div fills idle port (FIFO when busy); 1-cycle registered outputs.
// md_ready backpressure = FIFO not full (registered count). Optional stats counters under WB_SCHED_STATS_EN.
module wb_port_scheduler #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 Reset,
  wb_port_scheduler_if.slave   wb
`ifdef WB_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_md_stall,
  output logic [15:0]          stat_md_cancel
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [4:0]       fifo_reg_q [DEPTH];
  logic [31:0]      fifo_dat_q [DEPTH];
  logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d, match_v;
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      count_q, count_d;

  logic        rw1_q, rw1_d, rw2_q, rw2_d, old_q, old_d;
  logic [4:0]  wr1_q, wr1_d, wr2_q, wr2_d;
  logic [31:0] wd1_q, wd1_d, wd2_q, wd2_d;

  logic        p1, p2, free_port, md_acc, md_stale, md_keep;
  logic        head_ok, pop, push, use_head, use_md, grant;
  logic [4:0]  src_reg;
  logic [31:0] src_dat;
  logic [AW+1:0] cancel_n;

  assign wb.md_ready = (count_q < DEPTH_C);

  always_comb begin
    p1        = wb.w0_valid && (wb.w0_reg != 5'd0);
    p2        = wb.w1_valid && (wb.w1_reg != 5'd0);
    free_port = !p1 || !p2;
    md_acc    = wb.md_valid && wb.md_ready;
    for (int i = 0; i < DEPTH; i++) begin
      match_v[i] = fifo_vld_q[i] && ((p1 && fifo_reg_q[i] == wb.w0_reg) ||
                                     (p2 && fifo_reg_q[i] == wb.w1_reg));
    end
    md_stale = (p1 && wb.md_reg == wb.w0_reg) || (p2 && wb.md_reg == wb.w1_reg);
    md_keep  = md_acc && (wb.md_reg != 5'd0) && !md_stale;

    // Same-cycle cancellation feeds head selection so a stale head never reaches a port.
    fifo_vld_d = fifo_vld_q & ~match_v;
    head_ok    = fifo_vld_d[rd_q];
    pop        = 1'b0;
    use_head   = 1'b0;
    use_md     = 1'b0;
    if (count_q != '0) begin
      if (head_ok) begin
        if (free_port) begin
          pop      = 1'b1;
          use_head = 1'b1;
        end
      end else begin
        pop = 1'b1;
        if (count_q == ONE_C && md_keep && free_port) use_md = 1'b1;
      end
    end else if (md_keep && free_port) begin
      use_md = 1'b1;
    end
    push  = md_keep && !use_md;
    grant = use_head || use_md;

    src_reg = use_head ? fifo_reg_q[rd_q] : wb.md_reg;
    src_dat = use_head ? fifo_dat_q[rd_q] : wb.md_data;

    if (pop)  fifo_vld_d[rd_q] = 1'b0;
    if (push) fifo_vld_d[wr_q] = 1'b1;
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    rw1_d = p1 || (grant && !p1);
    wr1_d = p1 ? wb.w0_reg  : ((grant && !p1) ? src_reg : 5'd0);
    wd1_d = p1 ? wb.w0_data : ((grant && !p1) ? src_dat : 32'd0);
    rw2_d = p2 || (grant && p1);
    wr2_d = p2 ? wb.w1_reg  : ((grant && p1) ? src_reg : 5'd0);
    wd2_d = p2 ? wb.w1_data : ((grant && p1) ? src_dat : 32'd0);
    old_d = (p1 && p2) ? wb.w0_oldest : (grant && !p1);

    cancel_n = (AW+2)'(md_acc && !md_keep);
    for (int i = 0; i < DEPTH; i++) cancel_n = cancel_n + (AW+2)'(match_v[i]);
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      fifo_vld_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      rw1_q      <= 1'b0;
      wr1_q      <= '0;
      wd1_q      <= '0;
      rw2_q      <= 1'b0;
      wr2_q      <= '0;
      wd2_q      <= '0;
      old_q      <= 1'b0;
    end else begin
      fifo_vld_q <= fifo_vld_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      rw1_q      <= rw1_d;
      wr1_q      <= wr1_d;
      wd1_q      <= wd1_d;
      rw2_q      <= rw2_d;
      wr2_q      <= wr2_d;
      wd2_q      <= wd2_d;
      old_q      <= old_d;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset && push) begin
      fifo_reg_q[wr_q] <= wb.md_reg;
      fifo_dat_q[wr_q] <= wb.md_data;
    end
  end

  assign wb.RegWrite1       = rw1_q;
  assign wb.WriteReg_WB1    = wr1_q;
  assign wb.WriteData1      = wd1_q;
  assign wb.RegWrite2       = rw2_q;
  assign wb.WriteReg_WB2    = wr2_q;
  assign wb.WriteData2      = wd2_q;
  assign wb.Way_0_oldest_WB = old_q;

`ifdef WB_SCHED_STATS_EN
  logic [15:0] stall_q, stall_d, cancel_q, cancel_d;
  logic [16:0] cancel_sum;

  always_comb begin
    stall_d    = stall_q;
    if (wb.md_valid && !wb.md_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    cancel_sum = {1'b0, cancel_q} + 17'(cancel_n);
    cancel_d   = cancel_sum[16] ? 16'hFFFF : cancel_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      stall_q  <= '0;
      cancel_q <= '0;
    end else begin
      stall_q  <= stall_d;
      cancel_q <= cancel_d;
    end
  end

  assign stat_md_stall  = stall_q;
  assign stat_md_cancel = cancel_q;
`else
  logic unused_cancel;
  assign unused_cancel = ^cancel_n;
`endif

endmodule
